// File: rtl/rv_rsp_tag_demux_pkg.sv
// ---------------------------------------------------------------------------
// rv_rsp_tag_demux_pkg
//   Shared configuration helpers for the tagged response path. The matching
//   tag-inserting arbiter uses the same helpers, so both sides agree on how
//   many select bits are added to and removed from a tag.
//   Contents:
//     sel_width(n)            lane-select field width for n lanes
//     out_tag_width(tagw, n)  tag width once the select field is removed
//     buf_cnt_e               occupancy state of a 2-entry elastic buffer
// ---------------------------------------------------------------------------
package rv_rsp_tag_demux_pkg;

   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int out_tag_width(input int tagw, input int n);
      return tagw - sel_width(n);
   endfunction

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_cnt_e;

endpackage

// File: rtl/RV_bits_remove.sv
// ---------------------------------------------------------------------------
// RV_bits_remove
//   Removes an S-bit field located at bit POS of an N-bit word and closes the
//   gap. The removed field is returned separately so callers can use it as a
//   lane select.
//   Ports:
//     data_in   in  N      word containing the field
//     data_out  out N-S    word with the field removed
//     field_out out S      the removed field
// ---------------------------------------------------------------------------
module RV_bits_remove #(
   parameter int N   = 8,
   parameter int S   = 2,
   parameter int POS = 0
) (
   input  logic [N-1:0]   data_in,
   output logic [N-S-1:0] data_out,
   output logic [S-1:0]   field_out
);

   assign field_out = data_in[POS +: S];

   // Three shapes so no branch ever forms a zero-width or reversed slice.
   if (POS == 0) begin : g_at_lsb
      assign data_out = data_in[N-1:S];
   end else if (POS + S == N) begin : g_at_msb
      assign data_out = data_in[POS-1:0];
   end else begin : g_middle
      assign data_out = {data_in[N-1:POS+S], data_in[POS-1:0]};
   end

endmodule

// File: rtl/RV_elastic_buffer2.sv
// ---------------------------------------------------------------------------
// RV_elastic_buffer2
//   Two-entry FIFO used as a skid stage in front of each output port.
//   Handshake: an entry leaves when pop_valid && pop_ready. push_valid is
//   only honoured while count != BUF_FULL; the caller derives its own ready
//   from the count output, so there is no ready path back from pop_ready.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     push_valid   write push_data this cycle
//     push_data    entry to store
//     pop_valid    head entry present (count != BUF_EMPTY)
//     pop_data     head entry
//     pop_ready    downstream accepts the head entry
//     count        registered occupancy (state of the buffer)
// ---------------------------------------------------------------------------
module RV_elastic_buffer2
   import rv_rsp_tag_demux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_valid,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   output logic [W-1:0] pop_data,
   input  logic         pop_ready,
   output buf_cnt_e     count
);

   buf_cnt_e     count_q, count_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         push, pop, wr_idx;

   always_comb begin
      pop    = (count_q != BUF_EMPTY) && pop_ready;
      push   = push_valid && (count_q != BUF_FULL);
      // An empty buffer writes at the head slot; otherwise the other slot is
      // the tail. With push+pop at one entry, the head moves onto that slot.
      wr_idx = (count_q == BUF_EMPTY) ? rd_ptr_q : ~rd_ptr_q;

      mem_d = mem_q;
      if (push) begin
         mem_d[wr_idx] = push_data;
      end

      rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;

      count_d = count_q;
      unique case (count_q)
         BUF_EMPTY: if (push)               count_d = BUF_ONE;
         BUF_ONE:   if (push && !pop)       count_d = BUF_FULL;
                    else if (pop && !push)  count_d = BUF_EMPTY;
         BUF_FULL:  if (pop)                count_d = BUF_ONE;
         default:   count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= BUF_EMPTY;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Payload storage carries no reset; count gates its visibility.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign pop_valid = (count_q != BUF_EMPTY);
   assign pop_data  = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/rv_rsp_tag_demux.sv
// ---------------------------------------------------------------------------
// rv_rsp_tag_demux
//   Steers a tagged response stream to one of NUM_OUTPUTS ports using a
//   select field embedded in the tag, strips that field, and buffers each
//   port in a 2-entry elastic buffer so ports stall independently.
//   Handshake: a transfer happens on any interface when valid && ready.
//   rsp_ready_in depends only on buffer occupancy and the incoming tag.
//   Ports:
//     clk, reset       clock, synchronous active-high reset
//     rsp_valid_in     input response valid
//     rsp_data_in      input payload (DATAW)
//     rsp_tag_in       input tag including select field (TAGW)
//     rsp_ready_in     input response accepted this cycle when valid
//     rsp_valid_out    per-port valid
//     rsp_data_out     per-port payload, port i at [i*DATAW +: DATAW]
//     rsp_tag_out      per-port stripped tag, port i at [i*OTAGW +: OTAGW]
//     rsp_ready_out    per-port downstream ready
//     sel_err          registered pulse per dropped out-of-range response
// ---------------------------------------------------------------------------
module rv_rsp_tag_demux
   import rv_rsp_tag_demux_pkg::*;
#(
   parameter  int NUM_OUTPUTS = 4,
   parameter  int DATAW       = 32,
   parameter  int TAGW        = 8,
   parameter  int SEL_POS     = 0,
   localparam int SELW        = sel_width(NUM_OUTPUTS),
   localparam int OTAGW       = out_tag_width(TAGW, NUM_OUTPUTS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rsp_valid_in,
   input  logic [DATAW-1:0]             rsp_data_in,
   input  logic [TAGW-1:0]              rsp_tag_in,
   output logic                         rsp_ready_in,
   output logic [NUM_OUTPUTS-1:0]       rsp_valid_out,
   output logic [NUM_OUTPUTS*DATAW-1:0] rsp_data_out,
   output logic [NUM_OUTPUTS*OTAGW-1:0] rsp_tag_out,
   input  logic [NUM_OUTPUTS-1:0]       rsp_ready_out,
   output logic                         sel_err
);

   // One extra bit so the range test is meaningful for any NUM_OUTPUTS.
   localparam logic [SELW:0] NUM_OUT_W = (SELW+1)'(NUM_OUTPUTS);

   logic [SELW-1:0]        sel;
   logic [SELW:0]          sel_ext;
   logic                   sel_in_range;
   logic                   sel_full;
   logic [OTAGW-1:0]       tag_stripped;
   logic [NUM_OUTPUTS-1:0] buf_full;
   logic [NUM_OUTPUTS-1:0] buf_push;
   logic                   sel_err_q, sel_err_d;

   RV_bits_remove #(
      .N   (TAGW),
      .S   (SELW),
      .POS (SEL_POS)
   ) u_bits_remove (
      .data_in   (rsp_tag_in),
      .data_out  (tag_stripped),
      .field_out (sel)
   );

   always_comb begin
      sel_ext      = {1'b0, sel};
      sel_in_range = (sel_ext < NUM_OUT_W);

      sel_full = 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (sel_ext == (SELW+1)'(i)) sel_full = buf_full[i];
      end

      // Out-of-range responses are always taken so they can be dropped.
      rsp_ready_in = !sel_in_range || !sel_full;

      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         buf_push[i] = rsp_valid_in && rsp_ready_in && (sel_ext == (SELW+1)'(i));
      end

      sel_err_d = rsp_valid_in && !sel_in_range;
   end

   always_ff @(posedge clk) begin
      if (reset) sel_err_q <= 1'b0;
      else       sel_err_q <= sel_err_d;
   end

   assign sel_err = sel_err_q;

   for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_port
      buf_cnt_e                 cnt;
      logic [DATAW+OTAGW-1:0]   head;

      RV_elastic_buffer2 #(
         .W (DATAW + OTAGW)
      ) u_buf (
         .clk        (clk),
         .reset      (reset),
         .push_valid (buf_push[g]),
         .push_data  ({rsp_data_in, tag_stripped}),
         .pop_valid  (rsp_valid_out[g]),
         .pop_data   (head),
         .pop_ready  (rsp_ready_out[g]),
         .count      (cnt)
      );

      assign buf_full[g]                   = (cnt == BUF_FULL);
      assign rsp_data_out[g*DATAW +: DATAW] = head[OTAGW +: DATAW];
      assign rsp_tag_out[g*OTAGW +: OTAGW]  = head[OTAGW-1:0];
   end

endmodule

// File: tb/tb_rv_rsp_tag_demux.sv
// ---------------------------------------------------------------------------
// tb_rv_rsp_tag_demux
//   Three instances: a 4-port demux with the select at the tag LSBs (main
//   target), a 4-port demux with the select in the middle of the tag, and a
//   3-port demux that can see out-of-range selects. The main instance is
//   checked every cycle against per-port queues of expected responses.
// ---------------------------------------------------------------------------
module tb_rv_rsp_tag_demux;

   logic clk;
   logic reset;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Main instance: 4 ports, select at bit 0.
   logic         a_valid_in, a_ready_in, a_sel_err;
   logic [31:0]  a_data_in;
   logic [7:0]   a_tag_in;
   logic [3:0]   a_valid_out, a_ready_out;
   logic [127:0] a_data_out;
   logic [23:0]  a_tag_out;

   // Mid-field select instance: 4 ports, select at bit 3.
   logic         b_valid_in, b_ready_in, b_sel_err;
   logic [31:0]  b_data_in;
   logic [7:0]   b_tag_in;
   logic [3:0]   b_valid_out, b_ready_out;
   logic [127:0] b_data_out;
   logic [23:0]  b_tag_out;

   // Three-port instance.
   logic         c_valid_in, c_ready_in, c_sel_err;
   logic [31:0]  c_data_in;
   logic [7:0]   c_tag_in;
   logic [2:0]   c_valid_out, c_ready_out;
   logic [95:0]  c_data_out;
   logic [17:0]  c_tag_out;

   rv_rsp_tag_demux #(.NUM_OUTPUTS(4), .DATAW(32), .TAGW(8), .SEL_POS(0)) dut (
      .clk(clk), .reset(reset),
      .rsp_valid_in(a_valid_in), .rsp_data_in(a_data_in), .rsp_tag_in(a_tag_in),
      .rsp_ready_in(a_ready_in), .rsp_valid_out(a_valid_out), .rsp_data_out(a_data_out),
      .rsp_tag_out(a_tag_out), .rsp_ready_out(a_ready_out), .sel_err(a_sel_err)
   );

   rv_rsp_tag_demux #(.NUM_OUTPUTS(4), .DATAW(32), .TAGW(8), .SEL_POS(3)) dut_mid (
      .clk(clk), .reset(reset),
      .rsp_valid_in(b_valid_in), .rsp_data_in(b_data_in), .rsp_tag_in(b_tag_in),
      .rsp_ready_in(b_ready_in), .rsp_valid_out(b_valid_out), .rsp_data_out(b_data_out),
      .rsp_tag_out(b_tag_out), .rsp_ready_out(b_ready_out), .sel_err(b_sel_err)
   );

   rv_rsp_tag_demux #(.NUM_OUTPUTS(3), .DATAW(32), .TAGW(8), .SEL_POS(0)) dut_odd (
      .clk(clk), .reset(reset),
      .rsp_valid_in(c_valid_in), .rsp_data_in(c_data_in), .rsp_tag_in(c_tag_in),
      .rsp_ready_in(c_ready_in), .rsp_valid_out(c_valid_out), .rsp_data_out(c_data_out),
      .rsp_tag_out(c_tag_out), .rsp_ready_out(c_ready_out), .sel_err(c_sel_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Expected contents of each port of the main instance, head first:
   // {data[31:0], stripped_tag[5:0]}.
   logic [37:0] mq [4][$];

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Remove a 2-bit field at bit pos by arithmetic on the tag value.
   function automatic logic [5:0] strip_tag(input logic [7:0] t, input int pos);
      int v, low, high;
      v    = int'(t);
      low  = v % (1 << pos);
      high = v >> (pos + 2);
      return 6'((high << pos) | low);
   endfunction

   // One cycle on the main instance: drive at the falling edge, compare the
   // outputs with the model, then advance the model across the next rising edge.
   task automatic cyc_a(input logic v, input logic [7:0] tag, input logic [31:0] data,
                        input logic [3:0] rdy);
      int          s;
      logic        exp_rdy;
      logic [37:0] hd;
      @(negedge clk);
      a_valid_in  = v;
      a_tag_in    = tag;
      a_data_in   = data;
      a_ready_out = rdy;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("a_valid_out", a_valid_out[i], mq[i].size() != 0);
         if (mq[i].size() != 0) begin
            hd = mq[i][0];
            check("a_data_out", a_data_out[i*32 +: 32], hd[37:6]);
            check("a_tag_out", a_tag_out[i*6 +: 6], hd[5:0]);
         end
      end
      s       = int'(tag[1:0]);
      exp_rdy = (mq[s].size() < 2);
      check("a_ready_in", a_ready_in, exp_rdy);
      check("a_sel_err", a_sel_err, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (rdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
      end
      if (v && exp_rdy) mq[s].push_back({data, strip_tag(tag, 0)});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d1, d2, d3, d4, dm;

      reset = 1'b1;
      a_valid_in = 1'b0; a_data_in = '0; a_tag_in = '0; a_ready_out = '0;
      b_valid_in = 1'b0; b_data_in = '0; b_tag_in = '0; b_ready_out = '0;
      c_valid_in = 1'b0; c_data_in = '0; c_tag_in = '0; c_ready_out = '0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      #1;
      check("rst_a_valid", a_valid_out, 4'b0000);
      check("rst_a_ready", a_ready_in, 1'b1);
      check("rst_a_err", a_sel_err, 1'b0);
      check("rst_b_valid", b_valid_out, 4'b0000);
      check("rst_c_valid", c_valid_out, 3'b000);
      check("rst_c_ready", c_ready_in, 1'b1);
      check("rst_c_err", c_sel_err, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      // ---- mid-field select ----
      dm = $urandom;
      @(negedge clk);
      b_valid_in = 1'b1; b_tag_in = 8'b1010_1101; b_data_in = dm;
      #1;
      check("mid_ready", b_ready_in, 1'b1);
      @(negedge clk);
      b_valid_in = 1'b0;
      #1;
      check("mid_valid", b_valid_out, 4'b0010);
      check("mid_tag", b_tag_out[6 +: 6], 6'b101_101);
      check("mid_data", b_data_out[32 +: 32], dm);

      // ---- out-of-range on the 3-port instance ----
      @(negedge clk);
      c_valid_in = 1'b1; c_tag_in = {6'h2A, 2'b11}; c_data_in = $urandom;
      #1;
      check("oor_ready", c_ready_in, 1'b1);
      @(negedge clk);
      c_valid_in = 1'b0;
      #1;
      check("oor_err_pulse", c_sel_err, 1'b1);
      check("oor_no_valid", c_valid_out, 3'b000);
      @(negedge clk);
      #1;
      check("oor_err_clear", c_sel_err, 1'b0);
      // back-to-back drops hold the pulse high for two cycles
      @(negedge clk);
      c_valid_in = 1'b1; c_tag_in = {6'h01, 2'b11};
      @(negedge clk);
      c_tag_in = {6'h02, 2'b11};
      #1;
      check("oor_b2b_1", c_sel_err, 1'b1);
      @(negedge clk);
      c_valid_in = 1'b0;
      #1;
      check("oor_b2b_2", c_sel_err, 1'b1);
      @(negedge clk);
      #1;
      check("oor_b2b_end", c_sel_err, 1'b0);
      // an in-range response on the 3-port instance still lands on port 2
      @(negedge clk);
      c_valid_in = 1'b1; c_tag_in = {6'h07, 2'b10}; c_data_in = 32'hCAFE_0002;
      @(negedge clk);
      c_valid_in = 1'b0;
      #1;
      check("odd_valid", c_valid_out, 3'b100);
      check("odd_tag", c_tag_out[12 +: 6], 6'h07);
      check("odd_data", c_data_out[64 +: 32], 32'hCAFE_0002);

      // ---- single response on the main instance ----
      cyc_a(1'b1, 8'hB6, 32'hDEAD_BEEF, 4'hF);
      check("single_ready", a_ready_in, 1'b1);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);
      check("single_valid", a_valid_out, 4'b0100);
      check("single_tag", a_tag_out[12 +: 6], 6'h2D);
      check("single_data", a_data_out[64 +: 32], 32'hDEAD_BEEF);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);

      // ---- backpressure on port 1 ----
      d1 = $urandom; d2 = $urandom; d3 = $urandom; d4 = $urandom;
      cyc_a(1'b1, {6'h11, 2'b01}, d1, 4'b1101);
      cyc_a(1'b1, {6'h22, 2'b01}, d2, 4'b1101);
      cyc_a(1'b1, {6'h33, 2'b01}, d3, 4'b1101);
      check("bp_third_blocked", a_ready_in, 1'b0);
      cyc_a(1'b1, {6'h3C, 2'b11}, d4, 4'b1101);
      check("bp_port3_accepted", a_ready_in, 1'b1);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);
      check("bp_head_first", a_tag_out[6 +: 6], 6'h11);
      cyc_a(1'b1, {6'h33, 2'b01}, d3, 4'hF);
      check("bp_head_second", a_tag_out[6 +: 6], 6'h22);
      check("bp_retry_ready", a_ready_in, 1'b1);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);
      check("bp_head_third", a_tag_out[6 +: 6], 6'h33);
      check("bp_data_third", a_data_out[32 +: 32], d3);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);

      // ---- streaming 100 responses to port 0 ----
      for (int k = 0; k < 100; k++) begin
         cyc_a(1'b1, {6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'hF);
         check("stream_ready", a_ready_in, 1'b1);
      end
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);

      // ---- randomized traffic and backpressure ----
      for (int k = 0; k < 300; k++) begin
         cyc_a(1'($urandom_range(0, 1)), 8'($urandom), $urandom, 4'($urandom_range(0, 15)));
      end
      repeat (4) cyc_a(1'b0, 8'h00, 32'h0, 4'hF);

      // ---- reset mid-flight ----
      cyc_a(1'b1, {6'h01, 2'b00}, $urandom, 4'h0);
      cyc_a(1'b1, {6'h02, 2'b00}, $urandom, 4'h0);
      cyc_a(1'b1, {6'h03, 2'b10}, $urandom, 4'h0);
      cyc_a(1'b1, {6'h04, 2'b10}, $urandom, 4'h0);
      cyc_a(1'b0, 8'h00, 32'h0, 4'h0);
      check("mf_filled", a_valid_out, 4'b0101);
      @(negedge clk);
      reset = 1'b1;
      a_valid_in = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mf_valid_after_rst", a_valid_out, 4'b0000);
      check("mf_ready_after_rst", a_ready_in, 1'b1);
      for (int i = 0; i < 4; i++) mq[i].delete();
      cyc_a(1'b1, {6'h15, 2'b00}, 32'h0BAD_F00D, 4'h0);
      cyc_a(1'b0, 8'h00, 32'h0, 4'h0);
      check("mf_new_alone", a_valid_out, 4'b0001);
      check("mf_new_tag", a_tag_out[0 +: 6], 6'h15);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);
      cyc_a(1'b0, 8'h00, 32'h0, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_rsp_tag_demux.md
# rv_rsp_tag_demux

Response demultiplexer for the memory/response return path. It takes a single tagged response stream, extracts a lane-select field from the tag, and strips that field from the tag with `RV_bits_remove`. It then delivers the response to one of `NUM_OUTPUTS` downstream ports, each fronted by a 2-entry elastic buffer. It sits directly downstream of an arbiter that inserted the select bits into the tag, and restores each requester's original tag.

## Interface
Parameters:
- `NUM_OUTPUTS`, 4: number of destination ports; must be ≥2.
- `DATAW`, 32: response payload width.
- `TAGW`, 8: incoming tag width.
- `SEL_POS`, 0: LSB position of the select field in the tag; must satisfy 0 ≤ SEL_POS ≤ TAGW−SELW.
- Derived: `SELW` = clog2(NUM_OUTPUTS); `OTAGW` = TAGW−SELW; must be ≥1.

Ports:
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `rsp_valid_in`  in  1  input response valid.
- `rsp_data_in`  in  DATAW  input payload.
- `rsp_tag_in`  in  TAGW  input tag, including the select field.
- `rsp_ready_in`  out  1  input accepted when valid && ready.
- `rsp_valid_out`  out  NUM_OUTPUTS  per-port valid.
- `rsp_data_out`  out  NUM_OUTPUTS*DATAW  per-port payload; port i occupies bits [i*DATAW +: DATAW].
- `rsp_tag_out`  out  NUM_OUTPUTS*OTAGW  per-port stripped tag; port i occupies [i*OTAGW +: OTAGW].
- `rsp_ready_out`  in  NUM_OUTPUTS  per-port downstream ready.
- `sel_err`  out  1  one-cycle pulse when a response with an out-of-range select is dropped.

## Operation
- Select: sel = rsp_tag_in[SEL_POS +: SELW].
- Stripped tag: `RV_bits_remove` with N=TAGW, S=SELW, POS=SEL_POS, applied to rsp_tag_in.
- Per-port buffer: 2-entry FIFO with `count` ∈ {0,1,2}. The head entry drives rsp_valid_out[i] = (count≠0). Data and tag come from the head slot.
- rsp_ready_in = (sel ≥ NUM_OUTPUTS) || (count[sel] < 2). It depends only on registered state and the input tag; there is no combinational path from rsp_ready_out to rsp_ready_in.
- Push: rsp_valid_in && rsp_ready_in && sel < NUM_OUTPUTS writes {data, stripped tag} into buffer sel.
- Pop on port i: rsp_valid_out[i] && rsp_ready_out[i].
- Count transitions per port:
  - 0 + push → 1.
  - 1 + push + pop → 1; the head advances and the new entry becomes the tail.
  - 1 + push only → 2.
  - 1 + pop only → 0.
  - 2 + pop → 1.
  - 2 + push: cannot occur, because ready is low.
- Ordering: FIFO order is preserved per port. There is no ordering guarantee across ports.
- Out-of-range select: this can only occur when NUM_OUTPUTS is not a power of two. The response is accepted (ready=1), dropped, and sel_err is high the following cycle.
- Ports are independent: a stall on one port never blocks traffic addressed to another port.

## Timing
- Latency: a response accepted at edge t is visible on rsp_valid_out[sel] after edge t, i.e. 1 cycle.
- Throughput: 1 response/cycle sustained per port while its downstream ready is held high.
- Reset:
  - All `count` = 0, all rsp_valid_out = 0, sel_err = 0.
  - The data and tag storage is not reset.
  - rsp_ready_in = 1 during and after reset.
- Reset mid-operation discards every buffered entry. No output valid is asserted in the cycle after reset deasserts.
- Valid/data on an output port stay stable until that port pops; there is no retraction.
- sel_err is registered: it pulses for exactly one cycle per dropped response, and back-to-back drops keep it high.

## Structure
- The lane-select width helper and the tag-width derivation (TAGW−clog2(N)) go in the shared GPU config package, for reuse by the matching tag-inserting arbiter.
- Natural sub-module: `RV_elastic_buffer2` (2-entry, parameterised width). It is instantiated NUM_OUTPUTS times in a generate loop.
- One `RV_bits_remove` instance is shared by all ports, because tag stripping happens before the buffers.

## Test plan
- Single response: NUM_OUTPUTS=4, TAGW=8, SEL_POS=0, tag=8'hB6, data=32'hDEAD_BEEF → port 2 valid one cycle later, tag_out=6'h2D, data matches; all other ports stay low.
- Backpressure: hold rsp_ready_out[1]=0 and send 3 responses to port 1 → the first two are accepted, rsp_ready_in drops on the third. A response to port 3 is still accepted in that cycle. Releasing port 1 drains the entries in order.
- Streaming: 100 consecutive responses to port 0 with its ready held high → one accepted per cycle, output in order, count never exceeds 1.
- Mid-field select: SEL_POS=3, tag=8'b1010_1101 → sel=2'b01 (bits[4:3]) to port 1, tag_out=6'b101_101.
- Out-of-range: NUM_OUTPUTS=3, tag select=2'b11 → accepted, no port valid, sel_err high for exactly one cycle.
- Reset mid-flight: fill port 0 and port 2 to 2 entries, then assert reset for 1 cycle → all valids 0 and ready 1 after reset. A new response to port 0 then appears alone.
